// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 execute-stage ALU: op codes, word width
// and the condition-code layout with its architectural reset value.
package y86_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  // Packed so that {zf,sf,of} reads as a 3-bit vector with zf in the MSB
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = 3'b100;

endpackage

// File: rtl/add_sub_w.sv
// WIDTH-bit two's complement adder/subtractor: sum = b + a, or b - a as b + ~a + 1,
// with the signed overflow of whichever operation was selected.
module add_sub_w #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] yOp;

  assign yOp   = sub_i ? ~a_i : a_i;
  assign sum_o = b_i + yOp + {{(WIDTH-1){1'b0}}, sub_i};

  // Both addends agree in sign but the sum does not; yOp already carries the inverted sign on SUB
  assign overflow_o = (b_i[WIDTH-1] == yOp[WIDTH-1]) && (sum_o[WIDTH-1] != b_i[WIDTH-1]);

endmodule

// File: rtl/y86_alu.sv
// Y86-64 execute-stage ALU: combinational result/overflow plus the ZF/SF/OF
// condition-code register consumed by jXX/cmovXX.
module y86_alu
  import y86_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  input  logic             set_cc,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zf,
  output logic             of,
  output logic             sf
);

  alu_op_e          op;
  logic             isSub;
  logic [WIDTH-1:0] sumRes;
  logic             sumOvf;
  cc_t              cc_d;
  cc_t              cc_q;

  assign op    = alu_op_e'(control);
  assign isSub = (op == ALU_SUB);

  add_sub_w #(.WIDTH(WIDTH)) uAddSub (
    .a_i       (a),
    .b_i       (b),
    .sub_i     (isSub),
    .sum_o     (sumRes),
    .overflow_o(sumOvf)
  );

  always_comb begin
    out      = sumRes;
    overflow = 1'b0;
    case (op)
      ALU_ADD,
      ALU_SUB: begin
        out      = sumRes;
        overflow = sumOvf;
      end
      ALU_AND: out = a & b;
      ALU_XOR: out = a ^ b;
      default: begin
        out      = sumRes;
        overflow = 1'b0;
      end
    endcase
  end

  always_comb begin
    cc_d.zf = (out == '0);
    cc_d.sf = out[WIDTH-1];
    cc_d.of = overflow;
  end

  // Flags visible this cycle are those of the previous OPq that asserted set_cc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= CC_RESET;
    end else if (set_cc) begin
      cc_q <= cc_d;
    end
  end

  assign zf = cc_q.zf;
  assign sf = cc_q.sf;
  assign of = cc_q.of;

endmodule

// File: tb/tb_y86_alu.sv
// Scoreboard bench for y86_alu: expected results are queued when stimulus is
// driven and popped when the combinational result or the next edge's flags are due.
module tb_y86_alu;
  import y86_pkg::*;

  localparam logic [63:0] MAX_S = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN_S = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  control;
  logic        set_cc;
  logic [63:0] out;
  logic        overflow;
  logic        zf;
  logic        of;
  logic        sf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [63:0] out;
    logic        ovf;
    logic [2:0]  cc;
  } combExp_t;

  typedef struct {
    string      name;
    logic [2:0] cc;
  } ccExp_t;

  combExp_t   combQ[$];
  ccExp_t     ccQ[$];
  logic [2:0] prevCc;

  y86_alu #(.WIDTH(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .control (control),
    .set_cc  (set_cc),
    .out     (out),
    .overflow(overflow),
    .zf      (zf),
    .of      (of),
    .sf      (sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [63:0] av, input logic [63:0] bv,
                               input logic [1:0] ctl, input logic sc);
    a       = av;
    b       = bv;
    control = ctl;
    set_cc  = sc;
  endtask

  task automatic pushComb(input string nm, input logic [63:0] o, input logic v, input logic [2:0] c);
    combExp_t e;
    e.name = nm;
    e.out  = o;
    e.ovf  = v;
    e.cc   = c;
    combQ.push_back(e);
  endtask

  task automatic pushCc(input string nm, input logic [2:0] c);
    ccExp_t e;
    e.name = nm;
    e.cc   = c;
    ccQ.push_back(e);
  endtask

  // Reference model built on sign-extended 65-bit arithmetic
  function automatic logic [64:0] modelAlu(input logic [63:0] av, input logic [63:0] bv,
                                           input logic [1:0] ctl);
    logic [64:0] full;
    logic [63:0] res;
    logic        v;
    res = '0;
    v   = 1'b0;
    case (ctl)
      2'b00: begin
        full = {bv[63], bv} + {av[63], av};
        res  = full[63:0];
        v    = full[64] != full[63];
      end
      2'b01: begin
        full = {bv[63], bv} - {av[63], av};
        res  = full[63:0];
        v    = full[64] != full[63];
      end
      2'b10: res = av & bv;
      default: res = av ^ bv;
    endcase
    return {v, res};
  endfunction

  task automatic test_reset;
    combExp_t ce;
    ccExp_t   fe;
    rst_n = 1'b1;
    applyStimulus(64'd0, 64'd0, ALU_ADD, 1'b0);
    #1 rst_n = 1'b0;
    applyStimulus(64'd3, 64'd4, ALU_ADD, 1'b1);
    pushComb("reset_comb", 64'd7, 1'b0, 3'b100);
    pushCc("reset_hold_edge", 3'b100);
    #1;
    ce = combQ.pop_front();
    checks++;
    if (out !== ce.out || overflow !== ce.ovf || {zf, sf, of} !== ce.cc) begin
      errors++;
      $display("[TB] FAIL %s: got out=%h ovf=%b cc=%b, expected out=%h ovf=%b cc=%b",
               ce.name, out, overflow, {zf, sf, of}, ce.out, ce.ovf, ce.cc);
    end
    @(posedge clk);
    #1;
    fe = ccQ.pop_front();
    checks++;
    if ({zf, sf, of} !== fe.cc) begin
      errors++;
      $display("[TB] FAIL %s: got cc=%b, expected cc=%b", fe.name, {zf, sf, of}, fe.cc);
    end
    @(negedge clk);
    set_cc = 1'b0;
    rst_n  = 1'b1;
    prevCc = 3'b100;
  endtask

  // Table entries: a, b, control, expected out, overflow, {zf,sf,of} after the edge
  task automatic runTable(input string tag, input logic [63:0] ta[], input logic [63:0] tb[],
                          input logic [1:0] tc[], input logic [63:0] to[], input logic tv[],
                          input logic [2:0] tf[]);
    combExp_t ce;
    ccExp_t   fe;
    for (int i = 0; i < ta.size(); i++) begin
      @(negedge clk);
      applyStimulus(ta[i], tb[i], tc[i], 1'b1);
      pushComb($sformatf("%s_out_%0d", tag, i), to[i], tv[i], prevCc);
      pushCc($sformatf("%s_cc_%0d", tag, i), tf[i]);
      #1;
      ce = combQ.pop_front();
      checks++;
      if (out !== ce.out || overflow !== ce.ovf || {zf, sf, of} !== ce.cc) begin
        errors++;
        $display("[TB] FAIL %s: got out=%h ovf=%b cc=%b, expected out=%h ovf=%b cc=%b",
                 ce.name, out, overflow, {zf, sf, of}, ce.out, ce.ovf, ce.cc);
      end
      @(posedge clk);
      #1;
      fe = ccQ.pop_front();
      checks++;
      if ({zf, sf, of} !== fe.cc) begin
        errors++;
        $display("[TB] FAIL %s: got cc=%b, expected cc=%b", fe.name, {zf, sf, of}, fe.cc);
      end
      prevCc = fe.cc;
    end
  endtask

  task automatic test_arith;
    logic [63:0] ta[] = '{64'd5, 64'd7, 64'd8, 64'd1, 64'd1, MIN_S, MIN_S, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] tb[] = '{64'd7, 64'd7, 64'd3, MAX_S, MIN_S, 64'd0, MIN_S, 64'd1};
    logic [1:0]  tc[] = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_ADD, ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD};
    logic [63:0] to[] = '{64'd12, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, MIN_S, MAX_S, MIN_S, 64'd0, 64'd0};
    logic        tv[] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  tf[] = '{3'b000, 3'b100, 3'b010, 3'b011, 3'b001, 3'b011, 3'b101, 3'b100};
    runTable("arith", ta, tb, tc, to, tv, tf);
  endtask

  task automatic test_logic;
    logic [63:0] ta[] = '{64'hF0F0, 64'hF0F0, MIN_S, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] tb[] = '{64'hFF00, 64'hFF00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [1:0]  tc[] = '{ALU_AND, ALU_XOR, ALU_AND, ALU_XOR};
    logic [63:0] to[] = '{64'hF000, 64'h0FF0, MIN_S, 64'd0};
    logic        tv[] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  tf[] = '{3'b000, 3'b000, 3'b010, 3'b100};
    runTable("logic", ta, tb, tc, to, tv, tf);
  endtask

  task automatic test_hold;
    combExp_t ce;
    ccExp_t   fe;
    @(negedge clk);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFF8, 64'h100, ALU_ADD, 1'b0);
    pushComb("hold_out", 64'hF8, 1'b0, prevCc);
    for (int i = 0; i < 3; i++) pushCc($sformatf("hold_cc_%0d", i), prevCc);
    #1;
    ce = combQ.pop_front();
    checks++;
    if (out !== ce.out || overflow !== ce.ovf || {zf, sf, of} !== ce.cc) begin
      errors++;
      $display("[TB] FAIL %s: got out=%h ovf=%b cc=%b, expected out=%h ovf=%b cc=%b",
               ce.name, out, overflow, {zf, sf, of}, ce.out, ce.ovf, ce.cc);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      fe = ccQ.pop_front();
      checks++;
      if ({zf, sf, of} !== fe.cc) begin
        errors++;
        $display("[TB] FAIL %s: got cc=%b, expected cc=%b", fe.name, {zf, sf, of}, fe.cc);
      end
    end
  endtask

  task automatic test_async_reset;
    combExp_t ce;
    ccExp_t   fe;
    @(negedge clk);
    applyStimulus(64'd1, MAX_S, ALU_ADD, 1'b1);
    pushCc("async_setup_cc", 3'b011);
    @(posedge clk);
    #1;
    fe = ccQ.pop_front();
    checks++;
    if ({zf, sf, of} !== fe.cc) begin
      errors++;
      $display("[TB] FAIL %s: got cc=%b, expected cc=%b", fe.name, {zf, sf, of}, fe.cc);
    end
    @(negedge clk);
    set_cc = 1'b0;
    #1 rst_n = 1'b0;
    pushComb("async_reset_now", MIN_S, 1'b1, 3'b100);
    pushComb("async_reset_track", 64'd5, 1'b0, 3'b100);
    #1;
    ce = combQ.pop_front();
    checks++;
    if (out !== ce.out || overflow !== ce.ovf || {zf, sf, of} !== ce.cc) begin
      errors++;
      $display("[TB] FAIL %s: got out=%h ovf=%b cc=%b, expected out=%h ovf=%b cc=%b",
               ce.name, out, overflow, {zf, sf, of}, ce.out, ce.ovf, ce.cc);
    end
    applyStimulus(64'd2, 64'd3, ALU_ADD, 1'b0);
    #1;
    ce = combQ.pop_front();
    checks++;
    if (out !== ce.out || overflow !== ce.ovf || {zf, sf, of} !== ce.cc) begin
      errors++;
      $display("[TB] FAIL %s: got out=%h ovf=%b cc=%b, expected out=%h ovf=%b cc=%b",
               ce.name, out, overflow, {zf, sf, of}, ce.out, ce.ovf, ce.cc);
    end
    #1 rst_n = 1'b1;
    pushCc("async_post_release_hold", 3'b100);
    pushCc("async_first_capture", 3'b000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      fe = ccQ.pop_front();
      checks++;
      if ({zf, sf, of} !== fe.cc) begin
        errors++;
        $display("[TB] FAIL %s: got cc=%b, expected cc=%b", fe.name, {zf, sf, of}, fe.cc);
      end
      @(negedge clk);
      set_cc = 1'b1;
    end
    prevCc = 3'b000;
  endtask

  task automatic test_random;
    logic [63:0] av;
    logic [63:0] bv;
    logic [1:0]  ctl;
    logic [64:0] m;
    logic [2:0]  ccNext;
    combExp_t    ce;
    ccExp_t      fe;
    for (int i = 0; i < 16; i++) begin
      av  = {$urandom, $urandom};
      bv  = (i % 4 == 3) ? av : {$urandom, $urandom};
      ctl = 2'($urandom_range(0, 3));
      m   = modelAlu(av, bv, ctl);
      ccNext = {(m[63:0] == 64'd0), m[63], m[64]};
      @(negedge clk);
      applyStimulus(av, bv, ctl, 1'b1);
      pushComb($sformatf("rand_out_%0d", i), m[63:0], m[64], prevCc);
      pushCc($sformatf("rand_cc_%0d", i), ccNext);
      #1;
      ce = combQ.pop_front();
      checks++;
      if (out !== ce.out || overflow !== ce.ovf || {zf, sf, of} !== ce.cc) begin
        errors++;
        $display("[TB] FAIL %s: got out=%h ovf=%b cc=%b, expected out=%h ovf=%b cc=%b",
                 ce.name, out, overflow, {zf, sf, of}, ce.out, ce.ovf, ce.cc);
      end
      @(posedge clk);
      #1;
      fe = ccQ.pop_front();
      checks++;
      if ({zf, sf, of} !== fe.cc) begin
        errors++;
        $display("[TB] FAIL %s: got cc=%b, expected cc=%b", fe.name, {zf, sf, of}, fe.cc);
      end
      prevCc = fe.cc;
    end
  endtask

  initial begin
    prevCc = 3'b100;
    test_reset;
    test_arith;
    test_logic;
    test_hold;
    test_async_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
